// File: rtl/bldc_deadtime_pkg.sv
// Shared types and helpers for the bldc gate-drive conditioning stage:
// phase FSM states, request decode codes and counter sizing.
package bldc_deadtime_pkg;

  localparam int NUM_PHASES = 3;
  localparam int PHASE_U    = 0;
  localparam int PHASE_V    = 1;
  localparam int PHASE_W    = 2;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HIGH = 2'd1,
    PH_LOW  = 2'd2
  } phase_state_e;

  typedef enum logic [1:0] {
    WANT_OFF     = 2'd0,
    WANT_HI      = 2'd1,
    WANT_LO      = 2'd2,
    WANT_ILLEGAL = 2'd3
  } want_e;

  function automatic want_e decode_want(input logic p, input logic n);
    case ({p, n})
      2'b10:   return WANT_HI;
      2'b01:   return WANT_LO;
      2'b11:   return WANT_ILLEGAL;
      default: return WANT_OFF;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One width serves both the dead-time and the min-pulse counter.
  function automatic int cnt_width(input int deadtime, input int min_pulse);
    return $clog2(max_int(deadtime, min_pulse) + 1);
  endfunction

endpackage

// File: rtl/bldc_deadtime_if.sv
// Signal bundle between the bldc PWM stage (master) and the dead-time
// conditioning stage (slave) that drives the power-stage gate pins.
interface bldc_deadtime_if;

  logic       enable;
  logic [2:0] req_p;
  logic [2:0] req_n;
  logic       fault_in;
  logic       fault_clear;
  logic [2:0] gate_p;
  logic [2:0] gate_n;
  logic       fault_latched;
  logic [7:0] illegal_cnt;

  modport master (
    output enable, req_p, req_n, fault_in, fault_clear,
    input  gate_p, gate_n, fault_latched, illegal_cnt
  );

  modport slave (
    input  enable, req_p, req_n, fault_in, fault_clear,
    output gate_p, gate_n, fault_latched, illegal_cnt
  );

endinterface

// File: rtl/bldc_deadtime_phase.sv
// One half-bridge phase: IDLE/HIGH/LOW FSM with dead-time and min-pulse
// counters, plus rising-edge detection of shoot-through requests.
module bldc_deadtime_phase
  import bldc_deadtime_pkg::*;
#(
  parameter int DEADTIME  = 50,
  parameter int MIN_PULSE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kill,
  input  logic req_p,
  input  logic req_n,
  output logic gate_p,
  output logic gate_n,
  output logic illegal_rise
);

  localparam int CW = cnt_width(DEADTIME, MIN_PULSE);
  localparam logic [CW-1:0] DEAD_LOAD  = CW'(DEADTIME - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(max_int(MIN_PULSE, 1) - 1);

  want_e        want;
  want_e        held;
  phase_state_e state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic         illegal_q;
  logic         gate_p_q, gate_n_q;

  assign want = decode_want(req_p, req_n);
  assign held = (state_q == PH_HIGH) ? WANT_HI : WANT_LO;

  // NOTE: every variable gets a default at the top of always_comb, so no
  // path through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    if (kill) begin
      state_d = PH_IDLE;
      dcnt_d  = DEAD_LOAD;
    end else begin
      unique case (state_q)
        PH_IDLE: begin
          if (dcnt_q != '0) begin
            dcnt_d = dcnt_q - CW'(1);
          end else if (want == WANT_HI) begin
            state_d = PH_HIGH;
            pcnt_d  = PULSE_LOAD;
          end else if (want == WANT_LO) begin
            state_d = PH_LOW;
            pcnt_d  = PULSE_LOAD;
          end
        end
        PH_HIGH, PH_LOW: begin
          if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - CW'(1);
          end else if (want != held) begin
            // Any change, including a direct HIGH<->LOW request, goes via IDLE.
            state_d = PH_IDLE;
            dcnt_d  = DEAD_LOAD;
          end
        end
        default: begin
          state_d = PH_IDLE;
          dcnt_d  = DEAD_LOAD;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PH_IDLE;
      dcnt_q    <= DEAD_LOAD;
      pcnt_q    <= '0;
      illegal_q <= 1'b0;
      gate_p_q  <= 1'b0;
      gate_n_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      pcnt_q    <= pcnt_d;
      illegal_q <= (want == WANT_ILLEGAL);
      gate_p_q  <= (state_d == PH_HIGH);
      gate_n_q  <= (state_d == PH_LOW);
    end
  end

  assign gate_p       = gate_p_q;
  assign gate_n       = gate_n_q;
  assign illegal_rise = (want == WANT_ILLEGAL) && !illegal_q;

endmodule

// File: rtl/bldc_deadtime.sv
// Gate-drive conditioning downstream of the bldc PWM stage: input register,
// fault synchroniser/latch, three phase FSMs and the shoot-through counter.
module bldc_deadtime
  import bldc_deadtime_pkg::*;
#(
  parameter int DEADTIME    = 50,
  parameter int MIN_PULSE   = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  bldc_deadtime_if.slave   bus
);

  logic [NUM_PHASES-1:0]  req_p_q, req_n_q;
  logic [SYNC_STAGES-1:0] fault_sync_q;
  logic                   fault_sync;
  logic                   fault_latched_q;
  logic                   kill;
  logic [NUM_PHASES-1:0]  gate_p, gate_n, illegal_rise;
  logic [1:0]             rise_sum;
  logic [8:0]             cnt_sum;
  logic [7:0]             illegal_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_p_q <= '0;
      req_n_q <= '0;
    end else begin
      req_p_q <= bus.req_p;
      req_n_q <= bus.req_n;
    end
  end

  // The synchronised fault kills directly so the bridge does not wait
  // an extra cycle for the latch to set.
  assign fault_sync = fault_sync_q[SYNC_STAGES-1];
  assign kill       = !bus.enable || fault_latched_q || fault_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_sync_q    <= '0;
      fault_latched_q <= 1'b0;
    end else begin
      fault_sync_q <= {fault_sync_q[SYNC_STAGES-2:0], bus.fault_in};
      if (fault_sync) begin
        fault_latched_q <= 1'b1;
      end else if (bus.fault_clear) begin
        fault_latched_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_phase
    bldc_deadtime_phase #(
      .DEADTIME  (DEADTIME),
      .MIN_PULSE (MIN_PULSE)
    ) u_phase (
      .clk          (clk),
      .rst_n        (rst_n),
      .kill         (kill),
      .req_p        (req_p_q[i]),
      .req_n        (req_n_q[i]),
      .gate_p       (gate_p[i]),
      .gate_n       (gate_n[i]),
      .illegal_rise (illegal_rise[i])
    );
  end

  assign rise_sum = 2'(illegal_rise[PHASE_U]) + 2'(illegal_rise[PHASE_V])
                  + 2'(illegal_rise[PHASE_W]);
  assign cnt_sum  = {1'b0, illegal_cnt_q} + {7'd0, rise_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else begin
      illegal_cnt_q <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

  assign bus.gate_p        = gate_p;
  assign bus.gate_n        = gate_n;
  assign bus.fault_latched = fault_latched_q;
  assign bus.illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_bldc_deadtime.sv
// Self-checking bench for bldc_deadtime: directed scenarios plus random
// requests, compared every cycle against a timestamp-based reference model.
module tb_bldc_deadtime;

  localparam int DT     = 4;
  localparam int MP     = 3;
  localparam int SS     = 2;
  localparam int MP_EFF = (MP < 1) ? 1 : MP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bldc_deadtime_if bus ();

  bldc_deadtime #(
    .DEADTIME    (DT),
    .MIN_PULSE   (MP),
    .SYNC_STAGES (SS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: each phase remembers the edge it went off or on.
  int            cyc;
  int            mode     [3];   // 0 off, 1 high, 2 low
  int            off_edge [3];
  int            on_edge  [3];
  logic [2:0]    m_rp, m_rn, m_ill_prev;
  logic [SS-1:0] m_sync;
  logic          m_lat;
  int            m_cnt;

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      mode[i] = 0; off_edge[i] = 0; on_edge[i] = 0;
    end
    m_rp = '0; m_rn = '0; m_ill_prev = '0; m_sync = '0; m_lat = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic       kill;
    logic       new_lat;
    logic [2:0] ill;
    int         want;
    cyc++;
    kill = !bus.enable || m_lat || m_sync[SS-1];
    for (int i = 0; i < 3; i++) begin
      want = (m_rp[i] && !m_rn[i]) ? 1 : (m_rn[i] && !m_rp[i]) ? 2 : 0;
      if (kill) begin
        mode[i] = 0; off_edge[i] = cyc;
      end else if (mode[i] == 0) begin
        if (want != 0 && cyc - off_edge[i] >= DT) begin
          mode[i] = want; on_edge[i] = cyc;
        end
      end else if (want != mode[i] && cyc - on_edge[i] >= MP_EFF) begin
        mode[i] = 0; off_edge[i] = cyc;
      end
    end
    ill        = m_rp & m_rn;
    m_cnt      = m_cnt + $countones(ill & ~m_ill_prev);
    if (m_cnt > 255) m_cnt = 255;
    m_ill_prev = ill;
    new_lat    = m_sync[SS-1] ? 1'b1 : (bus.fault_clear ? 1'b0 : m_lat);
    m_sync     = {m_sync[SS-2:0], bus.fault_in};
    m_lat      = new_lat;
    m_rp       = bus.req_p;
    m_rn       = bus.req_n;
  endtask

  function automatic logic [2:0] exp_gate(input int m);
    logic [2:0] g;
    for (int i = 0; i < 3; i++) g[i] = (mode[i] == m);
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("gate_p",        32'(bus.gate_p), 32'(exp_gate(1)));
    check("gate_n",        32'(bus.gate_n), 32'(exp_gate(2)));
    check("overlap",       32'(bus.gate_p & bus.gate_n), 32'd0);
    check("fault_latched", 32'(bus.fault_latched), 32'(m_lat));
    check("illegal_cnt",   32'(bus.illegal_cnt), 32'(m_cnt));
  endtask

  task automatic wait_u_high(input string tag);
    int n = 0;
    while (bus.gate_p[0] !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check(tag, 32'(bus.gate_p[0]), 32'd1);
  endtask

  initial begin
    int hi_cycles;
    int hold [3];
    int sel;

    bus.enable = 1'b1; bus.req_p = '0; bus.req_n = '0;
    bus.fault_in = 1'b0; bus.fault_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_gate_p", 32'(bus.gate_p), 32'd0);
    check("reset_gate_n", 32'(bus.gate_n), 32'd0);
    check("reset_fault",  32'(bus.fault_latched), 32'd0);
    check("reset_cnt",    32'(bus.illegal_cnt), 32'd0);

    // Release reset with u high requested: gate follows the 4th edge.
    bus.req_p = 3'b001;
    rst_n = 1'b1;
    repeat (3) step();
    check("t1_before_4th", 32'(bus.gate_p[0]), 32'd0);
    step();
    check("t1_after_4th", 32'(bus.gate_p), 32'd1);
    check("t1_gate_n", 32'(bus.gate_n), 32'd0);

    // High -> low in one request change.
    repeat (3) step();
    bus.req_p[0] = 1'b0; bus.req_n[0] = 1'b1;
    step();
    check("t2_edge1_hi", 32'(bus.gate_p[0]), 32'd1);
    step();
    check("t2_edge2_off", 32'(bus.gate_p[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_deadgap", 32'(bus.gate_n[0]), 32'd0);
    end
    step();
    check("t2_lo_on", 32'(bus.gate_n[0]), 32'd1);

    // Single-cycle low request on idle v stretches to MIN_PULSE.
    bus.req_n[1] = 1'b1;
    step();
    bus.req_n[1] = 1'b0;
    hi_cycles = 0;
    repeat (8) begin
      step();
      hi_cycles += int'(bus.gate_n[1]);
    end
    check("t3_min_pulse", 32'(hi_cycles), 32'(MP_EFF));

    // Two 10-cycle shoot-through requests on w.
    repeat (2) begin
      bus.req_p[2] = 1'b1; bus.req_n[2] = 1'b1;
      repeat (10) begin
        step();
        check("t4_w_off", 32'(bus.gate_p[2] | bus.gate_n[2]), 32'd0);
      end
      bus.req_p[2] = 1'b0; bus.req_n[2] = 1'b0;
      repeat (3) step();
    end
    check("t4_illegal_cnt", 32'(bus.illegal_cnt), 32'd2);

    // Fault shutdown, ignored clear, real clear and dead-time restart.
    bus.req_n[0] = 1'b0; bus.req_p[0] = 1'b1;
    wait_u_high("t5_u_high");
    bus.fault_in = 1'b1;
    repeat (3) step();
    check("t5_gates_off", 32'({bus.gate_p, bus.gate_n}), 32'd0);
    check("t5_latched",   32'(bus.fault_latched), 32'd1);
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    step();
    check("t5_clear_ignored", 32'(bus.fault_latched), 32'd1);
    bus.fault_in = 1'b0;
    repeat (4) step();
    check("t5_still_latched", 32'(bus.fault_latched), 32'd1);
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    check("t5_cleared", 32'(bus.fault_latched), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_dead_after_clear", 32'(bus.gate_p[0]), 32'd0);
    end
    step();
    check("t5_redrive", 32'(bus.gate_p[0]), 32'd1);

    // Random requests, enable drops, faults and clears.
    for (int i = 0; i < 3; i++) hold[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          sel = int'($urandom_range(0, 9));
          bus.req_p[i] = (sel <= 3) || (sel == 9);
          bus.req_n[i] = (sel >= 4 && sel <= 7) || (sel == 9);
          hold[i] = int'($urandom_range(1, 12));
        end else begin
          hold[i]--;
        end
      end
      bus.enable = ($urandom_range(0, 99) != 0);
      if (!bus.fault_in && $urandom_range(0, 399) == 0) bus.fault_in = 1'b1;
      else if (bus.fault_in && $urandom_range(0, 3) == 0) bus.fault_in = 1'b0;
      bus.fault_clear = ($urandom_range(0, 29) == 0);
      step();
    end
    bus.fault_in = 1'b0; bus.fault_clear = 1'b0; bus.enable = 1'b1;
    bus.req_p = 3'b001; bus.req_n = 3'b000;
    repeat (4) step();
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    wait_u_high("t6_u_high");

    // Reset mid-high drops the gates without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_gate_p", 32'(bus.gate_p), 32'd0);
    check("t6_async_gate_n", 32'(bus.gate_n), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_p = '0;

    // 100 toggles on all three phases give 300 events.
    repeat (100) begin
      bus.req_p = 3'b111; bus.req_n = 3'b111;
      step();
      bus.req_p = 3'b000; bus.req_n = 3'b000;
      step();
    end
    repeat (3) step();
    check("t6_saturated", 32'(bus.illegal_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
